// File: rtl/rd_addr_seq_pkg.sv
// ---------------------------------------------------------------------------
// rd_addr_seq_pkg
// Shared definitions for the read-side address sequencer.
//   state_t  : sequencer FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DIR_DOWN : step direction -1 (same encoding as the write-side counter mode)
//   DIR_UP   : step direction +1
// ---------------------------------------------------------------------------
package rd_addr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/rd_addr_step.sv
// ---------------------------------------------------------------------------
// rd_addr_step
// Loadable up/down address register. Load has priority over stepping; the
// register holds when en=0. Arithmetic wraps modulo 2^ADDR_BIT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   load       : load load_val this cycle
//   load_val   : value to load
//   en         : step by one this cycle
//   dir        : DIR_UP (+1) or DIR_DOWN (-1)
//   addr       : current register value
// ---------------------------------------------------------------------------
module rd_addr_step
    import rd_addr_seq_pkg::*;
#(
    parameter int ADDR_BIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [ADDR_BIT-1:0] load_val,
    input  logic                en,
    input  logic                dir,
    output logic [ADDR_BIT-1:0] addr
);

    localparam logic [ADDR_BIT-1:0] STEP_ONE = 1;

    // Wrap-around in either direction is intentional and silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                addr <= addr + STEP_ONE;
            end else begin
                addr <= addr - STEP_ONE;
            end
        end
    end

endmodule

// File: rtl/rd_addr_seq.sv
// ---------------------------------------------------------------------------
// rd_addr_seq
// Read-side address sequencer for the TPU on-chip buffers. On an accepted
// start it issues len_i consecutive addresses from base_addr_i, one per
// valid/ready handshake, flags the final beat and pulses done_o afterwards.
// Optional feature macro: RD_ADDR_SEQ_DOWN_EN (adds mode_i for descending
// walks; without it the walk is always ascending).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start_i       : start request, honoured only in IDLE
//   base_addr_i   : first address, latched on accepted start
//   len_i         : beat count, latched on accepted start (0 = no beats)
//   mode_i        : 1 ascending / 0 descending (RD_ADDR_SEQ_DOWN_EN only)
//   addr_o        : current read address
//   addr_valid_o  : addr_o is valid
//   addr_ready_i  : consumer accepts addr_o
//   last_o        : current valid beat is the final one
//   busy_o        : sequencer not in IDLE
//   done_o        : one-cycle completion pulse
// ---------------------------------------------------------------------------
module rd_addr_seq
    import rd_addr_seq_pkg::*;
#(
    parameter int ADDR_BIT = 8,
    parameter int LEN_BIT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_BIT-1:0] base_addr_i,
    input  logic [LEN_BIT-1:0]  len_i,
`ifdef RD_ADDR_SEQ_DOWN_EN
    input  logic                mode_i,
`endif
    output logic [ADDR_BIT-1:0] addr_o,
    output logic                addr_valid_o,
    input  logic                addr_ready_i,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [LEN_BIT-1:0] REM_ONE = 1;
    localparam logic [LEN_BIT-1:0] REM_TWO = 2;

    state_t             state;
    logic [LEN_BIT-1:0] remain;
    logic               dir_q;
    logic               addr_load;
    logic               addr_step;

    // Address loads only on a start that will actually issue beats, and
    // steps on every handshake except the final one, so addr_o keeps the
    // last issued address once the transfer completes.
    assign addr_load = (state == IDLE) && start_i && (len_i != '0);
    assign addr_step = (state == RUN) && addr_ready_i && (remain != REM_ONE);

`ifdef RD_ADDR_SEQ_DOWN_EN
    // Direction is captured with the start and held for the whole transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= DIR_DOWN;
        end else if (addr_load) begin
            dir_q <= mode_i;
        end
    end
`else
    assign dir_q = DIR_UP;
`endif

    rd_addr_step #(
        .ADDR_BIT (ADDR_BIT)
    ) u_addr_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (addr_load),
        .load_val (base_addr_i),
        .en       (addr_step),
        .dir      (dir_q),
        .addr     (addr_o)
    );

    // Sequencer FSM. Every output is a flop; valid/last are computed from
    // the registered state and remaining count only, so addr_ready_i never
    // reaches addr_valid_o combinationally. last_o is precomputed one
    // handshake ahead by looking at remain==2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            remain       <= '0;
            addr_valid_o <= 1'b0;
            last_o       <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            state        <= RUN;
                            remain       <= len_i;
                            addr_valid_o <= 1'b1;
                            last_o       <= (len_i == REM_ONE);
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (addr_ready_i) begin
                        if (remain == REM_ONE) begin
                            state        <= DONE;
                            addr_valid_o <= 1'b0;
                            last_o       <= 1'b0;
                            done_o       <= 1'b1;
                        end else begin
                            remain <= remain - REM_ONE;
                            last_o <= (remain == REM_TWO);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    addr_valid_o <= 1'b0;
                    last_o       <= 1'b0;
                    busy_o       <= 1'b0;
                    done_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_rd_addr_seq
// Self-checking bench for rd_addr_seq. The expected address of beat k is
// base +/- k (mod 256); the expected beat count is len; done follows the
// final handshake by one cycle and the block is idle one cycle later.
// Honours RD_ADDR_SEQ_DOWN_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_rd_addr_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] base_addr_i = '0;
    logic [7:0] len_i = '0;
`ifdef RD_ADDR_SEQ_DOWN_EN
    logic       mode_i = 1'b1;
`endif
    logic [7:0] addr_o;
    logic       addr_valid_o;
    logic       addr_ready_i = 1'b0;
    logic       last_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int failures = 0;

    rd_addr_seq #(
        .ADDR_BIT (8),
        .LEN_BIT  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
`ifdef RD_ADDR_SEQ_DOWN_EN
        .mode_i       (mode_i),
`endif
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPorts(input string tag, input bit v, input bit l, input bit b, input bit d);
        checkOutput({tag, "_valid"}, {31'd0, addr_valid_o}, {31'd0, v});
        checkOutput({tag, "_last"},  {31'd0, last_o},       {31'd0, l});
        checkOutput({tag, "_busy"},  {31'd0, busy_o},       {31'd0, b});
        checkOutput({tag, "_done"},  {31'd0, done_o},       {31'd0, d});
    endtask

    // Runs one transfer. Called at posedge+1; returns at posedge+1 with the
    // block back in IDLE. Ready comes from readyPattern (bit per cycle) or
    // is random; startNoise throws extra start requests that must be ignored.
    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] len, input bit ascend,
                                 input bit randomReady, input logic [31:0] readyPattern,
                                 input bit startNoise);
        int   idx;
        int   cyc;
        bit   dirUp;
        bit   rdy;
        logic [7:0] expAddr;
`ifdef RD_ADDR_SEQ_DOWN_EN
        dirUp  = ascend;
        mode_i = ascend;
`else
        dirUp  = 1'b1;
        if (ascend) begin end
`endif
        start_i      = 1'b1;
        base_addr_i  = base;
        len_i        = len;
        addr_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        if (len == 8'd0) begin
            checkPorts("zero_len", 1'b0, 1'b0, 1'b1, 1'b1);
            @(posedge clk); #1;
            checkPorts("zero_len_idle", 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < int'(len) && cyc < 2000) begin
            expAddr = dirUp ? base + idx[7:0] : base - idx[7:0];
            checkPorts("beat", 1'b1, idx == int'(len) - 1, 1'b1, 1'b0);
            checkOutput("beat_addr", {24'd0, addr_o}, {24'd0, expAddr});
            rdy = randomReady ? ($urandom_range(3) != 0) : ((cyc < 32) ? readyPattern[cyc] : 1'b1);
            addr_ready_i = rdy;
            if (startNoise) begin
                start_i     = 1'($urandom_range(1));
                base_addr_i = 8'($urandom);
                len_i       = 8'($urandom);
            end
            @(posedge clk); #1;
            if (rdy) idx++;
            cyc++;
        end
        if (cyc >= 2000) checkOutput("run_bound", cyc, {24'd0, len});
        checkPorts("done", 1'b0, 1'b0, 1'b1, 1'b1);
        start_i = startNoise ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        checkPorts("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        @(posedge clk); @(posedge clk); #1;
        checkPorts("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_addr", {24'd0, addr_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ascending, full throughput
        applyStimulus(8'h10, 8'd4, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        // Backpressure: stall two cycles on beat 2
        applyStimulus(8'h20, 8'd3, 1'b1, 1'b0, 32'h0000_0019, 1'b0);
        // Ascending wrap
        applyStimulus(8'hFE, 8'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
`ifdef RD_ADDR_SEQ_DOWN_EN
        // Descending wrap
        applyStimulus(8'h01, 8'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
`endif
        // Single beat and zero length
        applyStimulus(8'h55, 8'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(8'h77, 8'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        // Start pulses during RUN/DONE ignored
        applyStimulus(8'h30, 8'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);

        // Reset during beat 2 of a 5-beat transfer
        start_i      = 1'b1;
        base_addr_i  = 8'h40;
        len_i        = 8'd5;
        addr_ready_i = 1'b1;
`ifdef RD_ADDR_SEQ_DOWN_EN
        mode_i = 1'b1;
`endif
        @(posedge clk); #1;
        start_i = 1'b0;
        checkOutput("rst_beat1_addr", {24'd0, addr_o}, 32'h40);
        @(posedge clk); #1;
        checkOutput("rst_beat2_addr", {24'd0, addr_o}, 32'h41);
        rst_n = 1'b0;
        #1;
        checkPorts("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_reset_addr", {24'd0, addr_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("mid_reset_no_done", {31'd0, done_o}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'h40, 8'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Randomized transfers with random backpressure and start noise
        for (int t = 0; t < 25; t++) begin
            applyStimulus(8'($urandom), 8'($urandom_range(12)), 1'($urandom_range(1)),
                          1'b1, 32'd0, 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_addr_seq.md
# rd_addr_seq

Read-side address sequencer for the TPU on-chip buffers. The write path fills a buffer with a free-running up/down counter; this block drains it. On a start command it walks a contiguous address range of programmable length and issues one read address per valid/ready handshake toward the SRAM read port. It reports the final beat and completion so the tile controller can chain the next transfer.

## Interface
- `ADDR_BIT`, default 8: address width. Addresses wrap modulo 2^ADDR_BIT.
- `LEN_BIT`, default 8: transfer-length width. Maximum transfer is 2^LEN_BIT−1 beats.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  start a transfer. Sampled only in IDLE.
- `base_addr_i`  in  ADDR_BIT  first address. Latched on an accepted start.
- `len_i`  in  LEN_BIT  number of beats. Latched on an accepted start.
- `mode_i`  in  1  0 = descending, 1 = ascending. Present only with `RD_ADDR_SEQ_DOWN_EN`.
- `addr_o`  out  ADDR_BIT  current read address.
- `addr_valid_o`  out  1  `addr_o` is valid.
- `addr_ready_i`  in  1  consumer accepts `addr_o`.
- `last_o`  out  1  the current valid beat is the final one.
- `busy_o`  out  1  block is not in IDLE.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- FSM has three states, IDLE, RUN and DONE. Reset forces IDLE.
- All outputs reset to 0. Internal address and remaining-count registers also reset to 0.
- **IDLE**
  - On `start_i`=1 with `len_i`≠0: latch `addr`←`base_addr_i` and `remain`←`len_i`, then go to RUN.
  - On `start_i`=1 with `len_i`=0: go to DONE. No beats are issued.
- **RUN**
  - `addr_valid_o`=1.
  - `last_o`=1 when `remain`=1.
  - A handshake (`addr_valid_o` & `addr_ready_i`) with `remain`=1 moves the FSM to DONE.
  - Any other handshake steps `addr` by one and decrements `remain`.
- **Stall:** while valid and not ready, `addr_o`, `last_o` and `addr_valid_o` hold stable.
- **DONE:** `done_o`=1 for exactly one cycle, then return to IDLE.
- `busy_o` = (state≠IDLE).
- **Ignored start:** `start_i` in RUN or DONE is ignored and not queued.
- **Address arithmetic:** step is +1 (ascending) or −1 (descending), modulo 2^ADDR_BIT. Wrap-around is legal and silent: 0xFF+1 → 0x00, and 0x00−1 → 0xFF.
- **Reset mid-transfer:** returns immediately to IDLE with all outputs at 0. No `done_o` is generated.
- **Input stability:** `addr_ready_i` may toggle freely. No combinational path exists from `addr_ready_i` to `addr_valid_o`.

## Timing
- All outputs are registered.
- Accepted start in cycle t gives the first `addr_valid_o` in cycle t+1.
- Throughput is one address per cycle with `addr_ready_i` held high. An N-beat transfer occupies RUN for exactly N cycles.
- `done_o` asserts in the cycle after the last handshake.
- The next start is accepted no earlier than the cycle after `done_o`.
- Zero-length start in cycle t gives `done_o` in cycle t+1, with `addr_valid_o` never asserted.

## Configuration
- Macro: `RD_ADDR_SEQ_DOWN_EN`.
- **Defined:** `mode_i` port exists and is latched with the start. The step direction follows the latched value for the whole transfer.
- **Undefined:** no `mode_i` port. Direction is fixed ascending.

## Structure
- Shared package `rd_addr_seq_pkg` contains:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - direction constants: DIR_DOWN=1'b0, DIR_UP=1'b1 (same encoding as the write-side counter `mode`).
- One sub-module, `rd_addr_step`, is natural. It is a loadable up/down register with `load`, `load_val`, `en` and `dir`, holding when `en`=0. It is used for `addr`.
- The `remain` down-count stays inline in the top level.

## Test plan
- **Basic ascending:** base=0x10, len=4, ready=1 → addr 0x10,0x11,0x12,0x13 in cycles t+1..t+4; last_o on 0x13; done_o at t+5; busy_o low at t+6.
- **Backpressure:** base=0x20, len=3, ready low for 2 cycles on beat 2 → addr_o holds 0x21 stable while stalled; total 3 handshakes; done_o follows the final handshake by one cycle.
- **Wrap and descending** (macro defined): base=0xFE, len=3, mode=1 → 0xFE,0xFF,0x00; base=0x01, len=3, mode=0 → 0x01,0x00,0xFF.
- **Zero length and ignored start:** len=0 → done_o at t+1 with no valid. start pulses during RUN → no effect on addr sequence or beat count.
- **Reset mid-transfer:** rst_n low during beat 2 of len=5 → all outputs 0 immediately and no done_o. A new start after release runs a full, correct transfer.
